// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// hopper indices and the denomination value table (largest first).
package change_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_DENOM = 5;
  localparam int DENOM_W   = 3;

  localparam logic [DENOM_W-1:0] IDX_20 = 3'd0;
  localparam logic [DENOM_W-1:0] IDX_10 = 3'd1;
  localparam logic [DENOM_W-1:0] IDX_5  = 3'd2;
  localparam logic [DENOM_W-1:0] IDX_2  = 3'd3;
  localparam logic [DENOM_W-1:0] IDX_1  = 3'd4;

  localparam logic [7:0] DENOM_VAL [NUM_DENOM] = '{8'd20, 8'd10, 8'd5, 8'd2, 8'd1};

  function automatic logic is_valid_denom(input logic [DENOM_W-1:0] idx);
    return idx <= IDX_1;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Payout-side bus of the vending protocol: change request, hopper eject
// handshake, inventory refill and completion status.
interface change_dispenser_if #(parameter int INV_W = 8);
  logic             chg_valid;
  logic [7:0]       chg_amt;
  logic             chg_ready;
  logic             eject_req;
  logic [2:0]       eject_denom;
  logic             eject_ack;
  logic             refill_valid;
  logic [2:0]       refill_denom;
  logic [INV_W-1:0] refill_count;
  logic             done;
  logic             shortfall;
  logic [7:0]       residual;
  logic [7:0]       paid_total;
  logic             jam;

  modport master (
    output chg_valid, chg_amt, eject_ack, refill_valid, refill_denom, refill_count,
    input  chg_ready, eject_req, eject_denom, done, shortfall, residual, paid_total, jam
  );

  modport slave (
    input  chg_valid, chg_amt, eject_ack, refill_valid, refill_denom, refill_count,
    output chg_ready, eject_req, eject_denom, done, shortfall, residual, paid_total, jam
  );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Per-hopper coin counters: exact-load refill, decrement on eject ack,
// clear on jam. A refill colliding with an ack lands one coin lower.
module coin_inventory
  import change_pkg::*;
#(
  parameter int INV_W      = 8,
  parameter int INIT_COUNT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  input  logic               clr_en,
  input  logic [DENOM_W-1:0] op_idx,
  input  logic               refill_valid,
  input  logic [DENOM_W-1:0] refill_denom,
  input  logic [INV_W-1:0]   refill_count,
  output logic [INV_W-1:0]   level [NUM_DENOM]
);

  logic refill_ok;
  assign refill_ok = refill_valid && is_valid_denom(refill_denom);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NUM_DENOM; d++) level[d] <= INV_W'(INIT_COUNT);
    end else begin
      for (int d = 0; d < NUM_DENOM; d++) begin
        if (refill_ok && refill_denom == DENOM_W'(d)) begin
          if (dec_en && op_idx == DENOM_W'(d))
            level[d] <= (refill_count == '0) ? '0 : refill_count - INV_W'(1);
          else
            level[d] <= refill_count;
        end else if (clr_en && op_idx == DENOM_W'(d)) begin
          level[d] <= '0;
        end else if (dec_en && op_idx == DENOM_W'(d) && level[d] != '0) begin
          level[d] <= level[d] - INV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy largest-first coin selection over the
// hoppers, one req/ack eject at a time, with shortfall and jam reporting.
//
// state  | meaning
// IDLE   | ready for a change request
// SELECT | pick the largest affordable denomination still in stock
// EJECT  | eject_req held until ack or ack timeout (jam)
// DONE   | publish done/residual/shortfall, then back to IDLE
module change_dispenser
  import change_pkg::*;
#(
  parameter int INV_W       = 8,
  parameter int INIT_COUNT  = 20,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t             state;
  logic [7:0]         remaining;
  logic [7:0]         coin_val;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [INV_W-1:0]   inv_lvl [NUM_DENOM];

  logic               sel_found;
  logic [DENOM_W-1:0] sel_idx;
  logic [7:0]         sel_val;
  logic               ack_hit;
  logic               tmo_hit;

  assign ack_hit = (state == ST_EJECT) && bus.eject_ack;
  assign tmo_hit = (state == ST_EJECT) && !bus.eject_ack
                   && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  // Scan smallest-to-largest so the largest eligible denomination wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_val   = '0;
    for (int d = NUM_DENOM - 1; d >= 0; d--) begin
      if (DENOM_VAL[d] <= remaining && inv_lvl[d] != '0) begin
        sel_found = 1'b1;
        sel_idx   = DENOM_W'(d);
        sel_val   = DENOM_VAL[d];
      end
    end
  end

  coin_inventory #(
    .INV_W      (INV_W),
    .INIT_COUNT (INIT_COUNT)
  ) u_inv (
    .clk          (clk),
    .rst          (rst),
    .dec_en       (ack_hit),
    .clr_en       (tmo_hit),
    .op_idx       (bus.eject_denom),
    .refill_valid (bus.refill_valid),
    .refill_denom (bus.refill_denom),
    .refill_count (bus.refill_count),
    .level        (inv_lvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      coin_val        <= '0;
      tmo_cnt         <= '0;
      bus.chg_ready   <= 1'b1;
      bus.eject_req   <= 1'b0;
      bus.eject_denom <= IDX_20;
      bus.done        <= 1'b0;
      bus.shortfall   <= 1'b0;
      bus.residual    <= '0;
      bus.paid_total  <= '0;
      bus.jam         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.jam  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.chg_valid) begin
            remaining      <= bus.chg_amt;
            bus.paid_total <= '0;
            bus.chg_ready  <= 1'b0;
            state          <= (bus.chg_amt != '0) ? ST_SELECT : ST_DONE;
          end
        end
        ST_SELECT: begin
          if (sel_found) begin
            bus.eject_denom <= sel_idx;
            bus.eject_req   <= 1'b1;
            coin_val        <= sel_val;
            tmo_cnt         <= '0;
            state           <= ST_EJECT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (bus.eject_ack) begin
            remaining      <= remaining - coin_val;
            bus.paid_total <= bus.paid_total + coin_val;
            bus.eject_req  <= 1'b0;
            state          <= (remaining == coin_val) ? ST_DONE : ST_SELECT;
          end else if (tmo_hit) begin
            bus.jam       <= 1'b1;
            bus.eject_req <= 1'b0;
            state         <= ST_SELECT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_DONE: begin
          bus.done      <= 1'b1;
          bus.residual  <= remaining;
          bus.shortfall <= (remaining != '0);
          bus.chg_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
